// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [15:0] FILL_WORD       = 16'hffff;
    localparam int unsigned MAX_OUTSTANDING = 2;

    // Load pointer must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ram_addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM, write-first priority, registered read that holds
// its value whenever no read is issued.
module instr_mem_ram
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = ram_addr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a valid/ready fetch port (1-cycle latency,
// two outstanding requests) and a sequential bootloader load port.
//
// state    | meaning
// ST_RUN   | fetches accepted while fewer than two are outstanding
// ST_DRAIN | load requested; no new fetches, queued responses still delivered
// ST_LOAD  | bootloader writes words at the load pointer
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DEPTH  = 128,
    parameter logic [DATA_W-1:0] FILL   = FILL_WORD
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_busy_o,
    output logic              ld_overflow_o,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic              rsp_ready_i
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned RA_W  = ram_addr_width(DEPTH);

    state_e             state_q, state_d;
    // The loaded word count always equals the load pointer, so one register serves both.
    logic [PTR_W-1:0]   ld_ptr_q, ld_ptr_d;
    logic               ovf_q, ovf_d;

    logic               rd_vld_q, rd_vld_d;
    logic               rd_err_q, rd_err_d;
    logic               rd_fill_q, rd_fill_d;
    logic               sk_vld_q, sk_vld_d;
    logic [DATA_W-1:0]  sk_data_q, sk_data_d;
    logic               sk_err_q, sk_err_d;

    logic [1:0]         out_cnt;
    logic               accept, consume;
    logic               addr_oor, addr_unl;
    logic               ram_we, ram_re;
    logic [RA_W-1:0]    ram_addr;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  rd_word;

    assign out_cnt     = {1'b0, rd_vld_q} + {1'b0, sk_vld_q};
    assign req_ready_o = rst_n_i && (state_q == ST_RUN) && (out_cnt < 2'(MAX_OUTSTANDING));
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = rd_vld_q || sk_vld_q;
    assign consume     = rsp_valid_o && rsp_ready_i;

    assign addr_oor = req_addr_i >= ADDR_W'(DEPTH);
    assign addr_unl = req_addr_i >= ADDR_W'(ld_ptr_q);

    assign ram_re   = accept && !addr_unl;
    assign ram_addr = (state_q == ST_LOAD) ? ld_ptr_q[RA_W-1:0] : req_addr_i[RA_W-1:0];

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ld_data_i),
        .rdata_o (ram_rdata)
    );

    assign rd_word       = rd_fill_q ? FILL : ram_rdata;
    assign rsp_data_o    = sk_vld_q ? sk_data_q : ((rd_vld_q && !rd_fill_q) ? ram_rdata : FILL);
    assign rsp_err_o     = sk_vld_q ? sk_err_q : (rd_vld_q && rd_err_q);
    assign ld_busy_o     = (state_q == ST_LOAD);
    assign ld_overflow_o = ovf_q;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        ovf_d    = ovf_q;
        ram_we   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ld_start_i) begin
                    state_d = (out_cnt != 2'd0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_cnt == 2'd0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ld_start_i) begin
                    if (ld_ptr_q == PTR_W'(DEPTH)) begin
                        state_d = ST_RUN;
                        if (ld_valid_i) begin
                            ovf_d = 1'b1;
                        end
                    end else if (ld_valid_i) begin
                        ram_we   = 1'b1;
                        ld_ptr_d = ld_ptr_q + PTR_W'(1);
                        if (ld_last_i) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (ld_start_i) begin
            ld_ptr_d = '0;
            ovf_d    = 1'b0;
        end
    end

    // The RAM output stage always holds the youngest response; when it is still
    // unconsumed and a new read is issued, it moves into the skid register.
    always_comb begin
        rd_vld_d  = rd_vld_q;
        rd_err_d  = rd_err_q;
        rd_fill_d = rd_fill_q;
        sk_vld_d  = sk_vld_q;
        sk_data_d = sk_data_q;
        sk_err_d  = sk_err_q;
        if (accept) begin
            rd_vld_d  = 1'b1;
            rd_err_d  = addr_oor;
            rd_fill_d = addr_unl;
            if (rd_vld_q && !(consume && !sk_vld_q)) begin
                sk_vld_d  = 1'b1;
                sk_data_d = rd_word;
                sk_err_d  = rd_err_q;
            end else if (sk_vld_q && consume) begin
                sk_vld_d = 1'b0;
            end
        end else if (consume) begin
            if (sk_vld_q) begin
                sk_vld_d = 1'b0;
            end else begin
                rd_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_RUN;
            ld_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_fill_q <= 1'b1;
            sk_vld_q  <= 1'b0;
            sk_data_q <= FILL;
            sk_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            ovf_q     <= ovf_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_fill_q <= rd_fill_d;
            sk_vld_q  <= sk_vld_d;
            sk_data_q <= sk_data_d;
            sk_err_q  <= sk_err_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed sequences, a vector table and a randomized
// fetch phase checked against a queue-based reference model.
module tb_instr_mem_fetch;

    localparam int          DW    = 16;
    localparam int          AW    = 32;
    localparam int          DEPTH = 128;
    localparam logic [15:0] FILLV = 16'hffff;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_start, ld_valid, ld_last;
    logic [DW-1:0] ld_data;
    logic          ld_busy, ld_overflow;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid, rsp_err, rsp_ready;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL(FILLV)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .ld_start_i    (ld_start),
        .ld_valid_i    (ld_valid),
        .ld_data_i     (ld_data),
        .ld_last_i     (ld_last),
        .ld_busy_o     (ld_busy),
        .ld_overflow_o (ld_overflow),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_err_o     (rsp_err),
        .rsp_ready_i   (rsp_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] d;
        logic        e;
    } vec_t;

    logic [15:0] mmem [DEPTH];
    int          mptr    = 0;
    int          mloaded = 0;
    rsp_t        q[$];
    vec_t        vt[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic rsp_t model_rsp(input logic [31:0] a);
        rsp_t r;
        if (a >= 32'(DEPTH)) begin
            r.d = FILLV; r.e = 1'b1;
        end else if (a >= 32'(mloaded)) begin
            r.d = FILLV; r.e = 1'b0;
        end else begin
            r.d = mmem[a]; r.e = 1'b0;
        end
        return r;
    endfunction

    task automatic fetch_chk(input string nm, input logic [31:0] a, input logic [15:0] ed, input logic ee);
        int w;
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_data"}, 32'(rsp_data), 32'(ed));
        chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
        step();
    endtask

    task automatic load_start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        mptr     = 0;
        mloaded  = 0;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (mptr < DEPTH) begin
            mmem[mptr] = d;
            mptr++;
            mloaded = mptr;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        rv, rr, acc, cons;
        logic [31:0] ra;
        logic [15:0] exp_b2b [3];
        int          w;

        rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ld_busy), 32'd0);
        chk("rst_ovf", 32'(ld_overflow), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'(FILLV));
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();

        fetch_chk("noload0", 32'd0, FILLV, 1'b0);
        fetch_chk("noload5", 32'd5, FILLV, 1'b0);
        fetch_chk("noload200", 32'd200, FILLV, 1'b1);

        load_start();
        chk("ld_busy_on", 32'(ld_busy), 32'd1);
        load_word(16'hb105, 1'b0);
        load_word(16'hb104, 1'b0);
        load_word(16'h0211, 1'b1);
        chk("ld_busy_off", 32'(ld_busy), 32'd0);

        vt[0] = '{32'd0,           16'hb105, 1'b0};
        vt[1] = '{32'd1,           16'hb104, 1'b0};
        vt[2] = '{32'd2,           16'h0211, 1'b0};
        vt[3] = '{32'd3,           16'hffff, 1'b0};
        vt[4] = '{32'd127,         16'hffff, 1'b0};
        vt[5] = '{32'd128,         16'hffff, 1'b1};
        vt[6] = '{32'h0001_0001,   16'hffff, 1'b1};
        for (int i = 0; i < 7; i++) begin
            fetch_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].d, vt[i].e);
        end

        exp_b2b[0] = 16'hb105; exp_b2b[1] = 16'hb104; exp_b2b[2] = 16'h0211;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'd0;
        chk("b2b_rdy_first", 32'(req_ready), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_rdy%0d", i), 32'(req_ready), 32'd1);
            chk($sformatf("b2b_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i), 32'(rsp_data), 32'(exp_b2b[i]));
            req_addr = 32'(i + 1);
            if (i == 2) req_valid = 1'b0;
            step();
        end
        chk("b2b_idle", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'd0;
        step();
        chk("bp_rdy1", 32'(req_ready), 32'd1);
        req_addr = 32'd1;
        step();
        req_addr = 32'd2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_full%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp_hold%0d", i), 32'(rsp_data), 32'h0000_b105);
            chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_second", 32'(rsp_data), 32'h0000_b104);
        chk("bp_rdy_again", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("bp_third_valid", 32'(rsp_valid), 32'd1);
        chk("bp_third", 32'(rsp_data), 32'h0000_0211);
        step();
        chk("bp_idle", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'd0;
        step();
        req_addr = 32'd1;
        step();
        req_valid = 1'b0;
        ld_start  = 1'b1;
        step();
        ld_start = 1'b0;
        mptr = 0; mloaded = 0;
        chk("drain_busy", 32'(ld_busy), 32'd0);
        chk("drain_rdy", 32'(req_ready), 32'd0);
        chk("drain_d0", 32'(rsp_data), 32'h0000_b105);
        rsp_ready = 1'b1;
        step();
        chk("drain_d1", 32'(rsp_data), 32'h0000_b104);
        chk("drain_v1", 32'(rsp_valid), 32'd1);
        step();
        chk("drain_empty", 32'(rsp_valid), 32'd0);
        w = 0;
        while (ld_busy !== 1'b1 && w < 5) begin
            step();
            w++;
        end
        chk("drain_to_load", 32'(ld_busy), 32'd1);

        for (int i = 0; i < DEPTH; i++) load_word(16'($urandom), 1'b0);
        chk("full_busy", 32'(ld_busy), 32'd1);
        load_word(16'h5a5a, 1'b0);
        chk("ovf_set", 32'(ld_overflow), 32'd1);
        chk("ovf_busy", 32'(ld_busy), 32'd0);
        fetch_chk("ovf_rd", 32'd100, mmem[100], 1'b0);
        load_start();
        chk("ovf_clr", 32'(ld_overflow), 32'd0);
        chk("reload_busy", 32'(ld_busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) load_word(16'($urandom), 1'b0);
        chk("auto_busy", 32'(ld_busy), 32'd1);
        step();
        chk("auto_run", 32'(ld_busy), 32'd0);
        chk("auto_noovf", 32'(ld_overflow), 32'd0);
        fetch_chk("auto_rd", 32'(DEPTH - 1), mmem[DEPTH-1], 1'b0);

        load_start();
        load_word(16'h1111, 1'b0);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'h2222;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        mptr = 0; mloaded = 0;
        load_word(16'h3333, 1'b1);
        chk("prio_busy", 32'(ld_busy), 32'd0);
        fetch_chk("prio_a0", 32'd0, 16'h3333, 1'b0);
        fetch_chk("prio_a1", 32'd1, FILLV, 1'b0);

        load_start();
        for (int i = 0; i < 40; i++) load_word(16'($urandom), (i == 39));
        for (int c = 0; c < 600; c++) begin
            chk("rnd_valid", 32'(rsp_valid), 32'(q.size() > 0));
            chk("rnd_ready", 32'(req_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_data", 32'(rsp_data), 32'(q[0].d));
                chk("rnd_err", 32'(rsp_err), 32'(q[0].e));
            end
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 39));
                1: ra = 32'($urandom_range(0, DEPTH - 1));
                2: ra = 32'(DEPTH + $urandom_range(0, 3));
                default: ra = $urandom;
            endcase
            if (c >= 595) begin
                rv = 1'b0;
                rr = 1'b1;
            end
            acc  = rv && (q.size() < 2);
            cons = (q.size() > 0) && rr;
            req_valid = rv;
            req_addr  = ra;
            rsp_ready = rr;
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(model_rsp(ra));
            step();
        end
        req_valid = 1'b0;
        chk("rnd_drained", 32'(rsp_valid), 32'd0);

        load_start();
        load_word(16'hcafe, 1'b0);
        load_word(16'hbeef, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(ld_busy), 32'd0);
        chk("mrst_ovf", 32'(ld_overflow), 32'd0);
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_err", 32'(rsp_err), 32'd0);
        chk("mrst_data", 32'(rsp_data), 32'(FILLV));
        chk("mrst_ready", 32'(req_ready), 32'd0);
        mptr = 0; mloaded = 0;
        step();
        rst_n = 1'b1;
        step();
        fetch_chk("mrst_a0", 32'd0, FILLV, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
